// File: rtl/calc1_port_driver.sv
// Request-side driver for one calc1 requester port: accepts a full operation, drives the
// cmd/operand cycles, waits for the response or a timeout and hands back the result.
// Optional in-line expected-result checker: define CALC1_DRV_CHECK_EN.

module calc1_port_driver #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [0:3]  op_cmd,
   input  logic [0:31] op_data1,
   input  logic [0:31] op_data2,
   output logic [0:3]  port_cmd_out,
   output logic [0:31] port_data_out,
   input  logic [0:1]  port_resp_in,
   input  logic [0:31] port_data_in,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [0:1]  res_resp,
   output logic [0:31] res_data,
   output logic        res_timeout,
   output logic        res_mismatch,
   output logic        proto_err
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_OPND = 3'd2,
      ST_WAIT = 3'd3,
      ST_HOLD = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_r;
   state_t            state_s;
   logic [0:31]       op2_r;
   logic [0:31]       op2_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_s;
   logic [0:3]        port_cmd_s;
   logic [0:31]       port_data_s;
   logic              res_valid_s;
   logic [0:1]        res_resp_s;
   logic [0:31]       res_data_s;
   logic              res_timeout_s;
   logic              proto_err_s;

   // Ready is gated by reset so nothing is offered while the block is held in reset.
   assign op_ready = (state_r == ST_IDLE) && reset;

   // Next-state and next-output decode.
   always_comb begin
      state_s       = state_r;
      op2_s         = op2_r;
      cnt_s         = cnt_r;
      port_cmd_s    = 4'd0;
      port_data_s   = 32'd0;
      res_valid_s   = res_valid;
      res_resp_s    = res_resp;
      res_data_s    = res_data;
      res_timeout_s = res_timeout;

      if ((state_r != ST_WAIT) && (port_resp_in != 2'd0)) begin
         proto_err_s = 1'b1;
      end else begin
         proto_err_s = proto_err;
      end

      case (state_r)
         ST_IDLE: begin
            if (op_valid && op_ready) begin
               op2_s = op_data2;
               if (op_cmd == 4'd0) begin
                  state_s       = ST_HOLD;
                  res_valid_s   = 1'b1;
                  res_resp_s    = 2'd0;
                  res_data_s    = 32'd0;
                  res_timeout_s = 1'b0;
               end else begin
                  state_s     = ST_CMD;
                  port_cmd_s  = op_cmd;
                  port_data_s = op_data1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CMD: begin
            state_s     = ST_OPND;
            port_data_s = op2_r;
         end
         ST_OPND: begin
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_s = cnt_r + CNT_ONE;
            // A response in the final cycle still beats the timeout.
            if (port_resp_in != 2'd0) begin
               state_s       = ST_HOLD;
               res_valid_s   = 1'b1;
               res_resp_s    = port_resp_in;
               res_data_s    = port_data_in;
               res_timeout_s = 1'b0;
            end else if (cnt_r == CNT_LAST) begin
               state_s       = ST_HOLD;
               res_valid_s   = 1'b1;
               res_resp_s    = 2'd0;
               res_data_s    = 32'd0;
               res_timeout_s = 1'b1;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (res_ready) begin
               state_s     = ST_IDLE;
               res_valid_s = 1'b0;
               cnt_s       = {CNT_W{1'b0}};
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         op2_r         <= 32'd0;
         cnt_r         <= {CNT_W{1'b0}};
         port_cmd_out  <= 4'd0;
         port_data_out <= 32'd0;
         res_valid     <= 1'b0;
         res_resp      <= 2'd0;
         res_data      <= 32'd0;
         res_timeout   <= 1'b0;
         proto_err     <= 1'b0;
      end else begin
         state_r       <= state_s;
         op2_r         <= op2_s;
         cnt_r         <= cnt_s;
         port_cmd_out  <= port_cmd_s;
         port_data_out <= port_data_s;
         res_valid     <= res_valid_s;
         res_resp      <= res_resp_s;
         res_data      <= res_data_s;
         res_timeout   <= res_timeout_s;
         proto_err     <= proto_err_s;
      end
   end

`ifdef CALC1_DRV_CHECK_EN
   logic [0:3]  cmd_r;
   logic [0:31] op1_r;

   function automatic logic check_mismatch(input logic [0:3]  cmd,
                                           input logic [0:31] a,
                                           input logic [0:31] b,
                                           input logic [0:1]  resp,
                                           input logic [0:31] data);
      logic [32:0] sum;
      logic [0:1]  exp_resp;
      logic [0:31] exp_data;
      sum      = {1'b0, a} + {1'b0, b};
      exp_resp = 2'd2;
      exp_data = 32'd0;
      case (cmd)
         4'd1: begin
            if (sum[32]) begin
               exp_resp = 2'd2;
            end else begin
               exp_resp = 2'd1;
               exp_data = sum[31:0];
            end
         end
         4'd2: begin
            if (b > a) begin
               exp_resp = 2'd2;
            end else begin
               exp_resp = 2'd1;
               exp_data = a - b;
            end
         end
         4'd5: begin
            exp_resp = 2'd1;
            exp_data = a << b[27:31];
         end
         4'd6: begin
            exp_resp = 2'd1;
            exp_data = a >> b[27:31];
         end
         default: begin
            exp_resp = 2'd2;
            exp_data = 32'd0;
         end
      endcase
      return (resp != exp_resp) || ((resp == 2'd1) && (data != exp_data));
   endfunction

   // Operands kept for the checker once the port has moved on.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         cmd_r <= 4'd0;
         op1_r <= 32'd0;
      end else if ((state_r == ST_IDLE) && op_valid && op_ready) begin
         cmd_r <= op_cmd;
         op1_r <= op_data1;
      end else begin
         cmd_r <= cmd_r;
         op1_r <= op1_r;
      end
   end

   // Checker verdict, cleared for timeouts and cmd 0 results.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         res_mismatch <= 1'b0;
      end else if ((state_r == ST_WAIT) && (port_resp_in != 2'd0)) begin
         res_mismatch <= check_mismatch(cmd_r, op1_r, op2_r, port_resp_in, port_data_in);
      end else if ((state_s == ST_HOLD) && (state_r != ST_HOLD)) begin
         res_mismatch <= 1'b0;
      end else begin
         res_mismatch <= res_mismatch;
      end
   end
`else
   assign res_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_calc1_port_driver.sv
// Self-checking bench for calc1_port_driver: directed plan items plus randomized operations
// checked against a latency/result model of the driver and the calc1 arithmetic rules.

module tb_calc1_port_driver;

   localparam int TO = 64;

   logic        c_clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [3:0]  op_cmd;
   logic [31:0] op_data1;
   logic [31:0] op_data2;
   logic [3:0]  port_cmd_out;
   logic [31:0] port_data_out;
   logic [1:0]  port_resp_in;
   logic [31:0] port_data_in;
   logic        res_valid;
   logic        res_ready;
   logic [1:0]  res_resp;
   logic [31:0] res_data;
   logic        res_timeout;
   logic        res_mismatch;
   logic        proto_err;

   int checks   = 0;
   int failures = 0;

   calc1_port_driver #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .c_clk(c_clk), .reset(reset),
      .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
      .op_data1(op_data1), .op_data2(op_data2),
      .port_cmd_out(port_cmd_out), .port_data_out(port_data_out),
      .port_resp_in(port_resp_in), .port_data_in(port_data_in),
      .res_valid(res_valid), .res_ready(res_ready), .res_resp(res_resp),
      .res_data(res_data), .res_timeout(res_timeout),
      .res_mismatch(res_mismatch), .proto_err(proto_err)
   );

   always #5 c_clk = ~c_clk;

   // Negedge index (acceptance edge = index 0's preceding edge) at which res_valid is first seen.
   function automatic int exp_latency(input logic [3:0] cmd, input int delay);
      if (cmd == 4'd0) return 0;
      if (delay >= 0 && delay < TO) return 3 + delay;
      return 2 + TO;
   endfunction

   // What a correct calc1 answers: {resp, data}.
   function automatic logic [33:0] calc1_expect(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] s;
      s = {32'd0, a} + {32'd0, b};
      case (cmd)
         4'd1:    return (s > 64'h0000_0000_FFFF_FFFF) ? {2'd2, 32'd0} : {2'd1, s[31:0]};
         4'd2:    return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
         4'd5:    return {2'd1, a << b[4:0]};
         4'd6:    return {2'd1, a >> b[4:0]};
         default: return {2'd2, 32'd0};
      endcase
   endfunction

   // Offers one operation, plays calc1 (answers in WAIT cycle 'delay', -1 = never) and records the port trace.
   task automatic drive_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input int delay, input logic [1:0] rsp, input logic [31:0] rdata,
                           output int lat, output logic [3:0] c0, output logic [31:0] d0,
                           output logic [3:0] c1, output logic [31:0] d1, output bit stray);
      bit ready_seen;
      lat = -1; c0 = 4'd0; d0 = 32'd0; c1 = 4'd0; d1 = 32'd0; stray = 1'b0; ready_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge c_clk);
         if (op_ready) begin
            ready_seen = 1'b1;
            break;
         end
      end
      if (ready_seen) begin
         op_valid = 1'b1; op_cmd = cmd; op_data1 = a; op_data2 = b;
         for (int n = 0; n < 200; n++) begin
            @(negedge c_clk);
            op_valid = 1'b0; port_resp_in = 2'd0; port_data_in = 32'd0;
            if (n == 0) begin
               c0 = port_cmd_out; d0 = port_data_out;
            end else if (n == 1) begin
               c1 = port_cmd_out; d1 = port_data_out;
            end else if (port_cmd_out != 4'd0 || port_data_out != 32'd0) begin
               stray = 1'b1;
            end
            if (res_valid) begin
               lat = n;
               break;
            end
            if (cmd != 4'd0 && delay >= 0 && n == 2 + delay) begin
               port_resp_in = rsp; port_data_in = rdata;
            end
         end
      end
   endtask

   task automatic release_result();
      res_ready = 1'b1;
      @(negedge c_clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge c_clk);
      checks++;
      if ({op_ready, port_cmd_out, port_data_out, res_valid, res_resp, res_data, res_timeout, res_mismatch, proto_err} !== '0) begin
         failures++;
         $display("FAIL reset_state: got %h expected 0", {op_ready, port_cmd_out, port_data_out, res_valid, res_resp, res_data, res_timeout, res_mismatch, proto_err});
      end
      reset = 1'b1;
      @(negedge c_clk);
      checks++;
      if (op_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset: got %b expected 1", op_ready); end
   endtask

   task automatic test_add();
      int lat; logic [3:0] c0, c1; logic [31:0] d0, d1; bit stray;
      drive_op(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 3, 2'd1, 32'h0200_0000, lat, c0, d0, c1, d1, stray);
      checks++;
      if (lat !== exp_latency(4'd1, 3)) begin failures++; $display("FAIL add_latency: got %0d expected %0d", lat, exp_latency(4'd1, 3)); end
      checks++;
      if ({c0, d0} !== {4'd1, 32'h1}) begin failures++; $display("FAIL add_cmd_phase: got %h expected %h", {c0, d0}, {4'd1, 32'h1}); end
      checks++;
      if ({c1, d1} !== {4'd0, 32'h01FF_FFFF}) begin failures++; $display("FAIL add_opnd_phase: got %h expected %h", {c1, d1}, {4'd0, 32'h01FF_FFFF}); end
      checks++;
      if (stray !== 1'b0) begin failures++; $display("FAIL add_port_idle: got %b expected 0", stray); end
      checks++;
      if ({res_resp, res_data, res_timeout, res_mismatch} !== {2'd1, 32'h0200_0000, 1'b0, 1'b0}) begin
         failures++; $display("FAIL add_result: got %h expected %h", {res_resp, res_data, res_timeout, res_mismatch}, {2'd1, 32'h0200_0000, 1'b0, 1'b0});
      end
      release_result();
      checks++;
      if ({res_valid, op_ready} !== 2'b01) begin failures++; $display("FAIL add_handoff: got %b expected 01", {res_valid, op_ready}); end
   endtask

   task automatic test_timeout();
      int lat; logic [3:0] c0, c1; logic [31:0] d0, d1; bit stray;
      drive_op(4'd2, 32'd1, 32'd15, -1, 2'd0, 32'd0, lat, c0, d0, c1, d1, stray);
      checks++;
      if (lat !== 2 + TO) begin failures++; $display("FAIL timeout_latency: got %0d expected %0d", lat, 2 + TO); end
      checks++;
      if ({res_resp, res_data, res_timeout, res_mismatch} !== {2'd0, 32'd0, 1'b1, 1'b0}) begin
         failures++; $display("FAIL timeout_result: got %h expected %h", {res_resp, res_data, res_timeout, res_mismatch}, {2'd0, 32'd0, 1'b1, 1'b0});
      end
      release_result();
   endtask

   task automatic test_backpressure();
      int lat; logic [3:0] c0, c1; logic [31:0] d0, d1; bit stray;
      logic [31:0] a, b; logic [33:0] e;
      a = $urandom; b = $urandom; e = calc1_expect(4'd5, a, b);
      drive_op(4'd5, a, b, 1, e[33:32], e[31:0], lat, c0, d0, c1, d1, stray);
      checks++;
      if (lat !== exp_latency(4'd5, 1)) begin failures++; $display("FAIL bp_latency: got %0d expected %0d", lat, exp_latency(4'd5, 1)); end
      for (int i = 0; i < 10; i++) begin
         @(negedge c_clk);
         checks++;
         if ({res_valid, res_resp, res_data, res_timeout, op_ready, port_cmd_out, port_data_out} !== {1'b1, e[33:32], e[31:0], 1'b0, 1'b0, 4'd0, 32'd0}) begin
            failures++;
            $display("FAIL bp_hold: got %h expected %h", {res_valid, res_resp, res_data, res_timeout, op_ready, port_cmd_out, port_data_out}, {1'b1, e[33:32], e[31:0], 1'b0, 1'b0, 4'd0, 32'd0});
         end
      end
      release_result();
      checks++;
      if ({res_valid, op_ready} !== 2'b01) begin failures++; $display("FAIL bp_release: got %b expected 01", {res_valid, op_ready}); end
   endtask

   task automatic test_cmd0();
      int lat; logic [3:0] c0, c1; logic [31:0] d0, d1; bit stray;
      for (int i = 0; i < 4; i++) begin
         drive_op(4'd0, $urandom, $urandom, 0, 2'd1, 32'hFFFF_FFFF, lat, c0, d0, c1, d1, stray);
         checks++;
         if (lat !== 0) begin failures++; $display("FAIL cmd0_latency: got %0d expected 0", lat); end
         checks++;
         if ({c0, d0, res_resp, res_data, res_timeout, res_mismatch} !== '0) begin
            failures++; $display("FAIL cmd0_result: got %h expected 0", {c0, d0, res_resp, res_data, res_timeout, res_mismatch});
         end
         release_result();
      end
   endtask

   task automatic test_random();
      int lat, delay; logic [3:0] c0, c1, cmd; logic [31:0] d0, d1, a, b, rdata; bit stray;
      logic [1:0] rsp; logic [33:0] e; logic exp_mm; logic [34:0] exp_res;
      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 3) == 0) cmd = 4'($urandom_range(0, 15));
         else case ($urandom_range(0, 3))
            0: cmd = 4'd1;
            1: cmd = 4'd2;
            2: cmd = 4'd5;
            default: cmd = 4'd6;
         endcase
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
         delay = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 12));
         e = calc1_expect(cmd, a, b);
         if ($urandom_range(0, 1) == 1) begin rsp = e[33:32]; rdata = e[31:0]; end
         else begin rsp = 2'($urandom_range(1, 3)); rdata = $urandom; end
         drive_op(cmd, a, b, delay, rsp, rdata, lat, c0, d0, c1, d1, stray);
         if (cmd == 4'd0) begin exp_res = 35'd0; exp_mm = 1'b0; end
         else if (delay < 0) begin exp_res = {2'd0, 32'd0, 1'b1}; exp_mm = 1'b0; end
         else begin
            exp_res = {rsp, rdata, 1'b0};
`ifdef CALC1_DRV_CHECK_EN
            exp_mm = (rsp != e[33:32]) || (rsp == 2'd1 && rdata != e[31:0]);
`else
            exp_mm = 1'b0;
`endif
         end
         checks++;
         if (lat !== exp_latency(cmd, delay)) begin failures++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, exp_latency(cmd, delay)); end
         if (cmd != 4'd0) begin
            checks++;
            if ({c0, d0, c1, d1} !== {cmd, a, 4'd0, b}) begin failures++; $display("FAIL rnd_port[%0d]: got %h expected %h", i, {c0, d0, c1, d1}, {cmd, a, 4'd0, b}); end
         end
         checks++;
         if (stray !== 1'b0) begin failures++; $display("FAIL rnd_port_idle[%0d]: got %b expected 0", i, stray); end
         checks++;
         if ({res_resp, res_data, res_timeout} !== exp_res) begin failures++; $display("FAIL rnd_result[%0d]: got %h expected %h", i, {res_resp, res_data, res_timeout}, exp_res); end
         checks++;
         if (res_mismatch !== exp_mm) begin failures++; $display("FAIL rnd_mismatch[%0d]: got %b expected %b", i, res_mismatch, exp_mm); end
         release_result();
      end
      checks++;
      if (proto_err !== 1'b0) begin failures++; $display("FAIL rnd_proto_err: got %b expected 0", proto_err); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [3:0] c0, c1; logic [31:0] d0, d1, a, b; bit stray; logic [33:0] e;
      drive_op(4'd1, 32'd7, 32'd9, 0, 2'd1, 32'd16, lat, c0, d0, c1, d1, stray);
      a = $urandom; b = $urandom; e = calc1_expect(4'd6, a, b);
      res_ready = 1'b1; op_valid = 1'b1; op_cmd = 4'd6; op_data1 = a; op_data2 = b;
      @(negedge c_clk);
      res_ready = 1'b0;
      checks++;
      if ({res_valid, op_ready, port_cmd_out} !== {1'b0, 1'b1, 4'd0}) begin
         failures++; $display("FAIL b2b_not_early: got %h expected %h", {res_valid, op_ready, port_cmd_out}, {1'b0, 1'b1, 4'd0});
      end
      @(negedge c_clk);
      op_valid = 1'b0;
      checks++;
      if ({port_cmd_out, port_data_out} !== {4'd6, a}) begin failures++; $display("FAIL b2b_cmd_phase: got %h expected %h", {port_cmd_out, port_data_out}, {4'd6, a}); end
      @(negedge c_clk);
      checks++;
      if ({port_cmd_out, port_data_out} !== {4'd0, b}) begin failures++; $display("FAIL b2b_opnd_phase: got %h expected %h", {port_cmd_out, port_data_out}, {4'd0, b}); end
      @(negedge c_clk);
      port_resp_in = 2'd1; port_data_in = e[31:0];
      @(negedge c_clk);
      port_resp_in = 2'd0; port_data_in = 32'd0;
      checks++;
      if ({res_valid, res_resp, res_data, res_mismatch} !== {1'b1, 2'd1, e[31:0], 1'b0}) begin
         failures++; $display("FAIL b2b_result: got %h expected %h", {res_valid, res_resp, res_data, res_mismatch}, {1'b1, 2'd1, e[31:0], 1'b0});
      end
      release_result();
   endtask

   task automatic test_checker();
      int lat; logic [3:0] c0, c1; logic [31:0] d0, d1; bit stray;
      logic [1:0] rsp; logic [31:0] rdata; logic [33:0] e; logic exp_mm;
      e = calc1_expect(4'd2, 32'd1, 32'd15);
      for (int k = 0; k < 2; k++) begin
         rsp = (k == 0) ? 2'd2 : 2'd1;
         rdata = 32'd0;
`ifdef CALC1_DRV_CHECK_EN
         exp_mm = (rsp != e[33:32]) || (rsp == 2'd1 && rdata != e[31:0]);
`else
         exp_mm = 1'b0;
`endif
         drive_op(4'd2, 32'd1, 32'd15, 2, rsp, rdata, lat, c0, d0, c1, d1, stray);
         checks++;
         if ({res_resp, res_mismatch} !== {rsp, exp_mm}) begin failures++; $display("FAIL chk_sub[%0d]: got %b expected %b", k, {res_resp, res_mismatch}, {rsp, exp_mm}); end
         release_result();
      end
   endtask

   task automatic test_reset_mid_op();
      @(negedge c_clk);
      op_valid = 1'b1; op_cmd = 4'd3; op_data1 = 32'hA5A5_0001; op_data2 = 32'd2;
      @(negedge c_clk);
      op_valid = 1'b0;
      checks++;
      if (port_cmd_out !== 4'd3) begin failures++; $display("FAIL rst_cmd_before: got %h expected 3", port_cmd_out); end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({op_ready, port_cmd_out, port_data_out, res_valid, res_resp, res_data, res_timeout, res_mismatch, proto_err} !== '0) begin
         failures++; $display("FAIL rst_mid_cmd: got %h expected 0", {op_ready, port_cmd_out, port_data_out, res_valid, res_resp, res_data, res_timeout, res_mismatch, proto_err});
      end
      @(negedge c_clk);
      reset = 1'b1;
      @(negedge c_clk);
      op_valid = 1'b1; op_cmd = 4'd1; op_data1 = 32'd5; op_data2 = 32'd6;
      @(negedge c_clk);
      op_valid = 1'b0;
      repeat (6) @(negedge c_clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({op_ready, port_cmd_out, port_data_out, res_valid, res_resp, res_data, res_timeout, res_mismatch, proto_err} !== '0) begin
         failures++; $display("FAIL rst_mid_wait: got %h expected 0", {op_ready, port_cmd_out, port_data_out, res_valid, res_resp, res_data, res_timeout, res_mismatch, proto_err});
      end
      @(negedge c_clk);
      reset = 1'b1;
      @(negedge c_clk);
      port_resp_in = 2'd1; port_data_in = 32'd11;
      @(negedge c_clk);
      port_resp_in = 2'd0; port_data_in = 32'd0;
      checks++;
      if ({proto_err, res_valid, op_ready} !== 3'b101) begin failures++; $display("FAIL stray_resp: got %b expected 101", {proto_err, res_valid, op_ready}); end
      repeat (3) @(negedge c_clk);
      checks++;
      if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_err_sticky: got %b expected 1", proto_err); end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (proto_err !== 1'b0) begin failures++; $display("FAIL proto_err_clear: got %b expected 0", proto_err); end
      @(negedge c_clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; op_valid = 1'b0; op_cmd = 4'd0; op_data1 = 32'd0; op_data2 = 32'd0;
      port_resp_in = 2'd0; port_data_in = 32'd0; res_ready = 1'b0;
      test_reset();
      test_add();
      test_timeout();
      test_backpressure();
      test_cmd0();
      test_random();
      test_back_to_back();
      test_checker();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/calc1_port_driver.md
Name: calc1_port_driver

Overview:
- Request-side driver for one calc1 requester port; instantiated once per port (1..4) between the test sequencer and the calc1 DUV.
- Takes a complete operation (cmd, operand1, operand2) over a valid/ready handshake and drives calc1's two-cycle command/operand protocol.
- Waits for the port's nonzero response and returns response, data and timeout status over a second valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 64: WAIT-state cycles allowed before a timeout is declared (>=1).
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- c_clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation offered.
- op_ready  out  1  driver can accept an operation.
- op_cmd  in  [0:3]  calc1 command.
- op_data1  in  [0:31]  operand 1.
- op_data2  in  [0:31]  operand 2.
- port_cmd_out  out  [0:3]  connects to calc1 reqN_cmd_in.
- port_data_out  out  [0:31]  connects to calc1 reqN_data_in.
- port_resp_in  in  [0:1]  from calc1 out_respN.
- port_data_in  in  [0:31]  from calc1 out_dataN.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_resp  out  [0:1]  captured response.
- res_data  out  [0:31]  captured data.
- res_timeout  out  1  result is a timeout.
- res_mismatch  out  1  checker disagreement (see Optional Feature).
- proto_err  out  1  sticky: a nonzero response arrived outside WAIT.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; op_ready=0, port_cmd_out=0, port_data_out=0, res_valid=0, res_resp=0, res_data=0, res_timeout=0, res_mismatch=0, proto_err=0, counter=0.
- All outputs are registered except op_ready, which is decoded from state: op_ready=1 only in IDLE.
- States:
  - IDLE: on op_valid&&op_ready, latch cmd/op1/op2.
    - cmd==0: go to HOLD with res_resp=0, res_data=0, res_timeout=0. No port activity.
    - cmd!=0: go to CMD.
  - CMD (1 cycle): port_cmd_out=latched cmd, port_data_out=op1; go to OPND.
  - OPND (1 cycle): port_cmd_out=0, port_data_out=op2; go to WAIT.
  - WAIT: port_cmd_out=0, port_data_out=0; counter increments each cycle.
    - port_resp_in!=0: capture resp and data, res_timeout=0, go to HOLD.
    - Otherwise, when counter reaches TIMEOUT_CYCLES-1 and no response is present: res_resp=0, res_data=0, res_timeout=1, go to HOLD.
    - If a response arrives in the same cycle the timeout would fire, the response wins.
  - HOLD: res_valid=1; res_* held stable until res_ready=1 at an edge; then go to IDLE, res_valid=0, counter cleared.
- Latency: acceptance edge T. Command is on the port during cycle T..T+1, operand during T+1..T+2, and WAIT begins at T+2.
- A nonzero port_resp_in seen in IDLE, CMD, OPND or HOLD sets proto_err. It is cleared only by reset and has no other effect.
- Reset mid-operation: everything returns to reset values immediately and port_cmd_out drops to 0 asynchronously. Any in-flight calc1 response after reset release is flagged through proto_err.
- Back-to-back: at most one operation is outstanding. The next operation is accepted no earlier than the edge after result hand-off.

Optional Feature:
- Macro CALC1_DRV_CHECK_EN enables an in-line expected-result checker, evaluated when the result is captured.
  - Add (1): 33-bit sum. Carry out gives expected resp 2; otherwise resp 1 with the sum.
  - Sub (2): op2>op1 gives resp 2; otherwise resp 1 with op1-op2.
  - Shift left (5) / shift right (6): shift op1 by op2[27:31], resp 1.
  - Any other nonzero cmd: resp 2.
  - res_mismatch=1 when the resp differs, or when resp is 1 and the data differs. Data is not compared when resp is 2. Forced 0 on timeout and for cmd 0.
- Without the macro: res_mismatch is tied to 0 and no checker logic is built.

Test Plan:
- Add: op 1, 0x00000001, 0x01FFFFFF; calc1 model answers resp 1, data 0x02000000 three cycles into WAIT. Required: port shows cmd1/data 0x1 then cmd0/data 0x01FFFFFF, then res_valid with res_resp=1, res_data=0x02000000, res_timeout=0, res_mismatch=0.
- Timeout: op 2, 1, 15 and the model never responds. Required: res_valid asserts after exactly 64 WAIT cycles with res_timeout=1, res_resp=0, res_data=0.
- Backpressure: hold res_ready=0 for 10 cycles after a result. Required: res_* stable, op_ready=0, port idle; IDLE on the res_ready edge.
- cmd 0 with random operands. Required: port_cmd_out stays 0; res_valid one edge after acceptance with resp 0, data 0.
- Reset asserted mid-WAIT, then the model responds after release. Required: all outputs 0 immediately and proto_err=1 after the stray response.
- With CALC1_DRV_CHECK_EN, sub 1-15: model resp 2 gives res_mismatch=0; model resp 1, data 0 gives res_mismatch=1.
